evg_marker_gen: RTL and testbench
=================================

EVG_MARKER_GEN -- requirements
Module: evgMarkerGen

Interface
REQ-001 SHALL have parameter DEFAULT_PERIOD, default 24'd125000, reset value of the heartbeat period in evgClk cycles.
REQ-002 SHALL have parameter HEARTBEAT_CODE, default 8'h7A, the event code emitted for each heartbeat.
REQ-003 SHALL have parameter PPS_CODE, default 8'h7D, the event code emitted for each pulse-per-second edge.
REQ-004 SHALL have parameter DEBUG, default "false", the mark_debug attribute value on internal state.
REQ-005 SHALL have port evgClk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port evgReset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port csrStrobe, input, 1, a one-cycle write strobe for GPIO_OUT.
REQ-008 SHALL have port GPIO_OUT, input, 32: [31:8] period, [1] clear-overruns, [0] enable.
REQ-009 SHALL have port csr, output, 32: {period[23:0], 4'b0, ppsSeen, hbOverrun, ppsOverrun, enable}.
REQ-010 SHALL have port ppsIn, input, 1, asynchronous external pulse-per-second.
REQ-011 SHALL have port evgEventCode, output, 8, the event code offered to the transmitter.
REQ-012 SHALL have port evgEventValid, output, 1, high when evgEventCode is offered.
REQ-013 SHALL have port evgEventReady, input, 1, the transmitter accepts when valid and ready are both high.
REQ-014 SHALL have port evgHeartbeatMarker, output, 1, a one-cycle pulse on the cycle a HEARTBEAT_CODE is accepted.

Function
REQ-015 SHALL load period and enable from GPIO_OUT on csrStrobe, and SHALL clear both overrun bits when GPIO_OUT[1]=1 on the same strobe.
REQ-016 SHALL run a 24-bit down-counter while enable=1 and period>=2: it reloads to period-1 on reaching 0, raising a heartbeat request on that cycle.
REQ-017 SHALL stop the counter and raise no request while period<2.
REQ-018 SHALL reload the counter to period-1 on the cycle after any csrStrobe, so the first request after a write comes exactly period cycles later.
REQ-019 SHALL pass ppsIn through two synchronizing flops and SHALL raise a PPS request on a 0->1 transition of the synchronized signal; ppsIn high at cycle t gives the request at t+3.
REQ-020 SHALL set sticky ppsSeen on the first PPS request; ppsSeen is cleared only by reset.
REQ-021 SHALL hold one pending flag per source (hbPending, ppsPending), each set on the cycle after its request.
REQ-022 SHALL set the matching overrun bit and merge the new request (no second event) when a request arrives while its pending flag is still set.
REQ-023 SHALL load the registered output (code, valid) from the pending flags when the output is empty or being accepted that cycle, clearing the flag it consumed; PPS has priority over heartbeat.
REQ-024 SHALL support back-to-back accepts with no bubble, and the minimum latency from pending set to evgEventValid high is 1 cycle.
REQ-025 SHALL hold evgEventCode stable and keep evgEventValid high until the event is accepted; valid is never retracted.
REQ-026 SHALL, on simultaneous heartbeat and PPS requests, emit PPS_CODE first and HEARTBEAT_CODE on the next accept opportunity, with no overrun.
REQ-027 SHALL, when enable is written 0, clear hbPending, keep any event already in the output register until accepted, and keep PPS handling active.

Reset
REQ-028 SHALL, on evgReset, set evgEventValid=0, evgEventCode=0, evgHeartbeatMarker=0, pending flags=0, overruns=0, ppsSeen=0, enable=0, period=DEFAULT_PERIOD, counter=DEFAULT_PERIOD-1, and synchronizer flops=0.
REQ-029 SHALL, when reset is applied mid-handshake, drop the offered event; valid goes low on the cycle after evgReset is sampled high.

Configuration
REQ-030 SHALL, with EVG_MARKER_GEN_PPS_RESYNC_EN defined, reload the heartbeat counter to period-1 on each PPS request, so heartbeats are phase-aligned to PPS.
REQ-031 SHALL, without EVG_MARKER_GEN_PPS_RESYNC_EN, leave the heartbeat counter free-running and unaffected by PPS.

Verification
REQ-032 SHALL check: period=10, enable=1, ready held 1 -> HEARTBEAT_CODE every 10 cycles, and evgHeartbeatMarker pulses on each accept.
REQ-033 SHALL check: ppsIn rises on the same cycle a heartbeat request occurs -> output sequence 0x7D then 0x7A, ppsSeen=1, overruns=0.
REQ-034 SHALL check: ready held 0 for 25 cycles with period=10 -> a single 0x7A held stable, hbOverrun=1; a strobe with GPIO_OUT[1]=1 clears it.
REQ-035 SHALL check: period=1 written -> no heartbeat events for 100 cycles, and PPS still emitted.
REQ-036 SHALL check: with EVG_MARKER_GEN_PPS_RESYNC_EN, period=10, PPS request mid-count -> the next heartbeat request comes exactly 10 cycles after the PPS request; without the macro, spacing is unchanged.
REQ-037 SHALL check: evgReset asserted while valid=1 and ready=0 -> valid=0 next cycle and the csr period field reads DEFAULT_PERIOD.

Source files
------------

// File: rtl/evg_marker_gen.sv
// Heartbeat / pulse-per-second event-code source for the event transmitter.
// Define EVG_MARKER_GEN_PPS_RESYNC_EN to phase-align the heartbeat counter to each PPS edge.
module evg_marker_gen #(
   parameter logic [23:0] DEFAULT_PERIOD = 24'd125000,
   parameter logic [7:0]  HEARTBEAT_CODE = 8'h7A,
   parameter logic [7:0]  PPS_CODE       = 8'h7D,
   parameter string       DEBUG          = "false"
) (
   input  logic        evgClk,
   input  logic        evgReset,
   input  logic        csrStrobe,
   input  logic [31:0] GPIO_OUT,
   output logic [31:0] csr,
   input  logic        ppsIn,
   output logic [7:0]  evgEventCode,
   output logic        evgEventValid,
   input  logic        evgEventReady,
   output logic        evgHeartbeatMarker
);

   localparam logic [23:0] default_count = DEFAULT_PERIOD - 24'd1;

   logic [23:0] period_reg;
   logic [23:0] count_reg;
   logic        enable_reg;
   logic        pps_meta_reg;
   logic        pps_sync_reg;
   logic        pps_prev_reg;
   logic        pps_req_reg;
   logic        hb_pending_reg;
   logic        pps_pending_reg;
   logic        hb_overrun_reg;
   logic        pps_overrun_reg;
   logic        pps_seen_reg;
   logic        valid_reg;
   logic [7:0]  code_reg;
   logic        code_is_hb_reg;

   logic running;
   logic hb_req;
   logic load_out;
   logic take_pps;
   logic take_hb;
   logic clear_ovr;
   logic unused_gpio;

   assign running     = enable_reg && (period_reg >= 24'd2);
   assign hb_req      = running && (count_reg == 24'd0);
   assign load_out    = !valid_reg || evgEventReady;
   assign take_pps    = load_out && pps_pending_reg;
   assign take_hb     = load_out && !pps_pending_reg && hb_pending_reg;
   assign clear_ovr   = csrStrobe && GPIO_OUT[1];
   assign unused_gpio = ^GPIO_OUT[7:2];

   always_ff @(posedge evgClk) begin
      if (evgReset) begin
         period_reg      <= DEFAULT_PERIOD;
         count_reg       <= default_count;
         enable_reg      <= 1'b0;
         pps_meta_reg    <= 1'b0;
         pps_sync_reg    <= 1'b0;
         pps_prev_reg    <= 1'b0;
         pps_req_reg     <= 1'b0;
         hb_pending_reg  <= 1'b0;
         pps_pending_reg <= 1'b0;
         hb_overrun_reg  <= 1'b0;
         pps_overrun_reg <= 1'b0;
         pps_seen_reg    <= 1'b0;
         valid_reg       <= 1'b0;
         code_reg        <= 8'h00;
         code_is_hb_reg  <= 1'b0;
      end else begin
         // Request is registered so that ppsIn high at t yields a request at t+3.
         pps_meta_reg <= ppsIn;
         pps_sync_reg <= pps_meta_reg;
         pps_prev_reg <= pps_sync_reg;
         pps_req_reg  <= pps_sync_reg && !pps_prev_reg;

         if (csrStrobe) begin
            period_reg <= GPIO_OUT[31:8];
            enable_reg <= GPIO_OUT[0];
         end

         if (csrStrobe)
            count_reg <= GPIO_OUT[31:8] - 24'd1;
`ifdef EVG_MARKER_GEN_PPS_RESYNC_EN
         else if (pps_req_reg)
            count_reg <= period_reg - 24'd1;
`endif
         else if (hb_req)
            count_reg <= period_reg - 24'd1;
         else if (running)
            count_reg <= count_reg - 24'd1;

         pps_pending_reg <= (pps_pending_reg && !take_pps) || pps_req_reg;
         if (csrStrobe && !GPIO_OUT[0])
            hb_pending_reg <= 1'b0;
         else
            hb_pending_reg <= (hb_pending_reg && !take_hb) || hb_req;

         // A request meeting a pending flag that is not drained this cycle is merged.
         if (clear_ovr) begin
            hb_overrun_reg  <= 1'b0;
            pps_overrun_reg <= 1'b0;
         end else begin
            if (pps_req_reg && pps_pending_reg && !take_pps)
               pps_overrun_reg <= 1'b1;
            if (hb_req && hb_pending_reg && !take_hb)
               hb_overrun_reg <= 1'b1;
         end

         if (pps_req_reg)
            pps_seen_reg <= 1'b1;

         if (load_out) begin
            if (pps_pending_reg) begin
               valid_reg      <= 1'b1;
               code_reg       <= PPS_CODE;
               code_is_hb_reg <= 1'b0;
            end else if (hb_pending_reg) begin
               valid_reg      <= 1'b1;
               code_reg       <= HEARTBEAT_CODE;
               code_is_hb_reg <= 1'b1;
            end else begin
               valid_reg <= 1'b0;
            end
         end
      end
   end

   assign evgEventValid      = valid_reg;
   assign evgEventCode       = code_reg;
   assign evgHeartbeatMarker = valid_reg && evgEventReady && code_is_hb_reg;
   assign csr = {period_reg, 4'b0000, pps_seen_reg, hb_overrun_reg, pps_overrun_reg, enable_reg};

   // Single probe vector so an ILA can pick up the whole state in one net.
   if (DEBUG == "true") begin : g_debug_probe
      (* mark_debug = "true" *) logic [55:0] debug_state;
      assign debug_state = {count_reg, period_reg, enable_reg, pps_req_reg, hb_pending_reg,
                            pps_pending_reg, hb_overrun_reg, pps_overrun_reg, pps_seen_reg,
                            valid_reg};
   end

endmodule

// File: tb/tb_evg_marker_gen.sv
// Directed and randomized bench for evg_marker_gen against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_evg_marker_gen;

   localparam logic [23:0] DEF_P = 24'd125000;
   localparam logic [7:0]  HB    = 8'h7A;
   localparam logic [7:0]  PPS   = 8'h7D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        strobe = 1'b0;
   logic        pps_in = 1'b0;
   logic        ready = 1'b0;
   logic [31:0] gpio = 32'd0;
   logic [31:0] csr;
   logic [7:0]  code;
   logic        valid;
   logic        marker;

   evg_marker_gen #(
      .DEFAULT_PERIOD(DEF_P),
      .HEARTBEAT_CODE(HB),
      .PPS_CODE(PPS),
      .DEBUG("false")
   ) dut (
      .evgClk(clk),
      .evgReset(rst),
      .csrStrobe(strobe),
      .GPIO_OUT(gpio),
      .csr(csr),
      .ppsIn(pps_in),
      .evgEventCode(code),
      .evgEventValid(valid),
      .evgEventReady(ready),
      .evgHeartbeatMarker(marker)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   longint cyc = 0;

   // Reference model: heartbeat timing kept as an absolute cycle stamp.
   logic [23:0] m_period;
   logic        m_enable;
   longint      m_next_hb;
   logic [3:0]  m_hist;
   logic        m_hb_p, m_pps_p, m_hb_ovr, m_pps_ovr, m_seen, m_valid;
   logic [7:0]  m_code;

   logic [7:0] acc_code[$];
   longint     mark_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_period  = DEF_P;
      m_enable  = 1'b0;
      m_next_hb = -1;
      m_hist    = 4'd0;
      m_hb_p    = 1'b0;
      m_pps_p   = 1'b0;
      m_hb_ovr  = 1'b0;
      m_pps_ovr = 1'b0;
      m_seen    = 1'b0;
      m_valid   = 1'b0;
      m_code    = 8'h00;
   endtask

   task automatic cycle();
      logic hb_req, pps_req, load, c_pps, c_hb, exp_marker;
      @(negedge clk);
      exp_marker = m_valid && ready && (m_code == HB);
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("code", {24'd0, code}, {24'd0, m_code});
      chk("marker", {31'd0, marker}, {31'd0, exp_marker});
      chk("csr", csr, {m_period, 4'b0000, m_seen, m_hb_ovr, m_pps_ovr, m_enable});
      if (valid && ready) begin
         acc_code.push_back(code);
         $display("accept cycle %0d code 0x%02h marker %0b", cyc, code, marker);
      end
      if (marker) mark_cyc.push_back(cyc);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         hb_req  = m_enable && (m_period >= 24'd2) && (cyc == m_next_hb);
         pps_req = m_hist[2] && !m_hist[3];
         m_hist  = {m_hist[2:0], pps_in};
         load    = !m_valid || ready;
         c_pps   = load && m_pps_p;
         c_hb    = load && !m_pps_p && m_hb_p;
         if (load) begin
            if (m_pps_p) begin
               m_valid = 1'b1;
               m_code  = PPS;
            end else if (m_hb_p) begin
               m_valid = 1'b1;
               m_code  = HB;
            end else begin
               m_valid = 1'b0;
            end
         end
         if (pps_req && m_pps_p && !c_pps) m_pps_ovr = 1'b1;
         if (hb_req && m_hb_p && !c_hb) m_hb_ovr = 1'b1;
         m_pps_p = (m_pps_p && !c_pps) || pps_req;
         m_hb_p  = (m_hb_p && !c_hb) || hb_req;
         if (pps_req) m_seen = 1'b1;
         if (strobe) m_next_hb = cyc + longint'(gpio[31:8]);
`ifdef EVG_MARKER_GEN_PPS_RESYNC_EN
         else if (pps_req) m_next_hb = cyc + longint'(m_period);
`endif
         else if (hb_req) m_next_hb = cyc + longint'(m_period);
         if (strobe) begin
            m_period = gpio[31:8];
            m_enable = gpio[0];
            if (!gpio[0]) m_hb_p = 1'b0;
            if (gpio[1]) begin
               m_hb_ovr  = 1'b0;
               m_pps_ovr = 1'b0;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic write_csr(input logic [23:0] p, input logic clr, input logic en);
      gpio   = {p, 6'b000000, clr, en};
      strobe = 1'b1;
      cycle();
      strobe = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint s;
      longint exp_mark;
      logic [23:0] rp;

      // Reset state
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      run(3);
      rst = 1'b0;
      chk("rst_csr", csr, {DEF_P, 8'h00});
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_code", {24'd0, code}, 32'd0);

      // Period 10 heartbeats with ready held high
      ready = 1'b1;
      s = cyc;
      write_csr(24'd10, 1'b0, 1'b1);
      mark_cyc.delete();
      run(45);
      chk("hb_count", 32'(mark_cyc.size()), 32'd4);
      chk("hb_first", 32'(mark_cyc[0] - s), 32'd12);
      for (int i = 1; i < mark_cyc.size(); i++)
         chk("hb_spacing", 32'(mark_cyc[i] - mark_cyc[i-1]), 32'd10);

      // PPS request on the same cycle as a heartbeat request
      if (m_next_hb - cyc < 4) run(10);
      run(int'(m_next_hb - 3 - cyc));
      pps_in = 1'b1;
      acc_code.delete();
      run(8);
      pps_in = 1'b0;
      chk("sim_count", 32'(acc_code.size()), 32'd2);
      chk("sim_first_pps", {24'd0, acc_code[0]}, {24'd0, PPS});
      chk("sim_second_hb", {24'd0, acc_code[1]}, {24'd0, HB});
      chk("sim_pps_seen", {31'd0, csr[3]}, 32'd1);
      chk("sim_no_overrun", {30'd0, csr[2:1]}, 32'd0);

      // Back-pressure for 25 cycles spanning three heartbeat requests
      run(int'(m_next_hb - 1 - cyc));
      ready = 1'b0;
      acc_code.delete();
      run(25);
      chk("bp_no_accept", 32'(acc_code.size()), 32'd0);
      chk("bp_valid_held", {31'd0, valid}, 32'd1);
      chk("bp_code_held", {24'd0, code}, {24'd0, HB});
      chk("bp_hb_overrun", {31'd0, csr[2]}, 32'd1);
      ready = 1'b1;
      run(3);
      write_csr(24'd10, 1'b1, 1'b1);
      chk("bp_overrun_cleared", {30'd0, csr[2:1]}, 32'd0);
      run(15);

      // Period below 2: no heartbeats, PPS still handled
      write_csr(24'd1, 1'b0, 1'b1);
      acc_code.delete();
      mark_cyc.delete();
      for (int i = 0; i < 100; i++) begin
         pps_in = (i >= 20 && i < 25);
         cycle();
      end
      chk("p1_no_hb", 32'(mark_cyc.size()), 32'd0);
      chk("p1_pps_count", 32'(acc_code.size()), 32'd1);
      chk("p1_pps_code", {24'd0, acc_code[0]}, {24'd0, PPS});

      // PPS request mid-count
      s = cyc;
      write_csr(24'd10, 1'b0, 1'b1);
      run(12);
      pps_in = 1'b1;
      mark_cyc.delete();
      run(3);
      pps_in = 1'b0;
      run(20);
`ifdef EVG_MARKER_GEN_PPS_RESYNC_EN
      exp_mark = s + 28;
`else
      exp_mark = s + 22;
`endif
      chk("resync_next_hb", 32'(mark_cyc[0] - s), 32'(exp_mark - s));

      // Reset while an event is offered and not accepted
      ready = 1'b0;
      for (int i = 0; i < 30 && !valid; i++) cycle();
      chk("pre_rst_valid", {31'd0, valid}, 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_drop_valid", {31'd0, valid}, 32'd0);
      chk("rst_period", {8'd0, csr[31:8]}, {8'd0, DEF_P});
      chk("rst_status", {24'd0, csr[7:0]}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) pps_in = ~pps_in;
         strobe = 1'b0;
         rst = ($urandom_range(0, 1499) == 0);
         if ($urandom_range(0, 149) == 0) begin
            rp = 24'($urandom_range(0, 16));
            gpio = {rp, 6'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
            strobe = 1'b1;
         end
         cycle();
      end
      strobe = 1'b0;
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
